// File: rtl/uart_defs.sv
// Shared constants for the Wishbone UART transmitter: register offsets,
// STATUS/CTRL bit positions, reset divisor and FSM state encoding.
package uart_defs;

    localparam int unsigned DEFAULT_DIV_RST = 433;
    localparam int unsigned DIV_W           = 16;
    localparam int unsigned CTRL_W          = 4;
    localparam int unsigned BUS_W           = 32;

    localparam logic [1:0] ADR_TXDATA  = 2'd0;
    localparam logic [1:0] ADR_STATUS  = 2'd1;
    localparam logic [1:0] ADR_BAUDDIV = 2'd2;
    localparam logic [1:0] ADR_CTRL    = 2'd3;

    localparam int unsigned ST_FULL  = 0;
    localparam int unsigned ST_EMPTY = 1;
    localparam int unsigned ST_BUSY  = 2;
    localparam int unsigned ST_OVF   = 3;
    localparam int unsigned ST_COUNT = 8;

    localparam int unsigned CTRL_TX_EN   = 0;
    localparam int unsigned CTRL_IRQ_EN  = 1;
    localparam int unsigned CTRL_PAR_EN  = 2;
    localparam int unsigned CTRL_PAR_ODD = 3;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } tx_state_e;

endpackage

// File: rtl/wb_uart_tx_if.sv
// Wishbone classic bus bundle between the interconnect (master) and the
// UART transmitter (slave).
interface wb_uart_tx_if;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic        wb_we_i;
    logic [31:0] wb_adr_i;
    logic [3:0]  wb_sel_i;
    logic [31:0] wb_dat_i;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;

    modport slave (
        input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
        output wb_dat_o, wb_ack_o
    );

    modport master (
        output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
        input  wb_dat_o, wb_ack_o
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO of depth 2**FIFO_AW; pushes while full and pops
// while empty are ignored.
module uart_tx_fifo #(
    parameter int unsigned FIFO_AW = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [7:0]       wdata,
    input  logic             pop,
    output logic [7:0]       rdata_c,
    output logic             full_c,
    output logic             empty_c,
    output logic [FIFO_AW:0] count
);
    localparam int unsigned DEPTH = 1 << FIFO_AW;
    localparam int unsigned CW    = FIFO_AW + 1;

    logic [7:0]         mem_q [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      count_q, count_d;
    logic               do_push_c, do_pop_c;

    assign full_c    = (count_q == CW'(DEPTH));
    assign empty_c   = (count_q == '0);
    assign do_push_c = push & ~full_c;
    assign do_pop_c  = pop & ~empty_c;
    assign rdata_c   = mem_q[rd_ptr_q];
    assign count     = count_q;

    // Pointers wrap naturally at the FIFO_AW-bit width.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push_c) wr_ptr_d = wr_ptr_q + FIFO_AW'(1);
        if (do_pop_c)  rd_ptr_d = rd_ptr_q + FIFO_AW'(1);
        case ({do_push_c, do_pop_c})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push_c) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/wb_uart_tx.sv
// Wishbone classic slave that queues CPU bytes and sends them as 8N1 UART
// frames. Optional parity bit compiled in with UART_TX_PARITY_EN.
module wb_uart_tx
    import uart_defs::*;
#(
    parameter int unsigned FIFO_AW     = 4,
    parameter int unsigned DEFAULT_DIV = DEFAULT_DIV_RST
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    wb_uart_tx_if.slave wb,
    output logic        uart_txd_o,
    output logic        uart_int_o
);
    localparam int unsigned CW = FIFO_AW + 1;

    logic              ack_q, ack_d;
    logic [BUS_W-1:0]  dat_q, dat_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic              ovf_q, ovf_d;
    logic              int_q, int_d;
    logic              txd_q, txd_d;
    tx_state_e         state_q, state_d;
    logic [DIV_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        shift_q, shift_d;
`ifdef UART_TX_PARITY_EN
    logic              par_q, par_d;
`endif

    logic             req_c, wr_c, push_c, pop_c, load_c, tick_c, start_ok_c;
    logic [1:0]       adr_c;
    logic [BUS_W-1:0] rdata_c;
    logic [7:0]       fifo_rdata_c;
    logic             full_c, empty_c;
    logic [CW-1:0]    fifo_count;
    logic             unused_bus_c;

    // A request is taken only while ack is low; side effects land in the ack cycle.
    assign req_c      = wb.wb_cyc_i & wb.wb_stb_i & ~ack_q;
    assign wr_c       = ack_q & wb.wb_cyc_i & wb.wb_stb_i & wb.wb_we_i;
    assign adr_c      = wb.wb_adr_i[3:2];
    assign tick_c     = (cnt_q == '0);
    assign start_ok_c = ctrl_q[CTRL_TX_EN] & ~empty_c;
    assign unused_bus_c = ^{wb.wb_adr_i[31:4], wb.wb_adr_i[1:0],
                            wb.wb_sel_i[3:2], wb.wb_dat_i[31:16]};

    uart_tx_fifo #(.FIFO_AW(FIFO_AW)) u_fifo (
        .clk     (wb_clk_i),
        .rst     (wb_rst_i),
        .push    (push_c),
        .wdata   (wb.wb_dat_i[7:0]),
        .pop     (pop_c),
        .rdata_c (fifo_rdata_c),
        .full_c  (full_c),
        .empty_c (empty_c),
        .count   (fifo_count)
    );

    // Register read mux, sampled into dat_q when the request is accepted.
    always_comb begin
        rdata_c = '0;
        case (adr_c)
            ADR_STATUS: begin
                rdata_c[ST_FULL]        = full_c;
                rdata_c[ST_EMPTY]       = empty_c;
                rdata_c[ST_BUSY]        = (state_q != S_IDLE);
                rdata_c[ST_OVF]         = ovf_q;
                rdata_c[ST_COUNT +: CW] = fifo_count;
            end
            ADR_BAUDDIV: rdata_c[DIV_W-1:0]  = div_q;
            ADR_CTRL:    rdata_c[CTRL_W-1:0] = ctrl_q;
            default:     rdata_c = '0;
        endcase
    end

    // Bus handshake and register writes.
    always_comb begin
        ack_d  = req_c;
        dat_d  = (req_c && !wb.wb_we_i) ? rdata_c : '0;
        div_d  = div_q;
        ctrl_d = ctrl_q;
        ovf_d  = ovf_q;
        push_c = 1'b0;
        int_d  = ctrl_q[CTRL_IRQ_EN] & empty_c & (state_q == S_IDLE);
        if (wr_c) begin
            case (adr_c)
                ADR_TXDATA: push_c = wb.wb_sel_i[0];
                ADR_STATUS: if (wb.wb_sel_i[0] && wb.wb_dat_i[ST_OVF]) ovf_d = 1'b0;
                ADR_BAUDDIV: begin
                    if (wb.wb_sel_i[0]) div_d[7:0]  = wb.wb_dat_i[7:0];
                    if (wb.wb_sel_i[1]) div_d[15:8] = wb.wb_dat_i[15:8];
                end
                ADR_CTRL: if (wb.wb_sel_i[0]) begin
                    ctrl_d[1:0] = wb.wb_dat_i[1:0];
`ifdef UART_TX_PARITY_EN
                    ctrl_d[3:2] = wb.wb_dat_i[3:2];
`endif
                end
                default: ;
            endcase
        end
        // Overflow is judged on the pre-pop fill level.
        if (push_c && full_c) ovf_d = 1'b1;
    end

    // Transmit FSM: each bit lasts div_q+1 clocks, divisor sampled at bit start.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        txd_d   = txd_q;
        pop_c   = 1'b0;
        load_c  = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            S_IDLE: load_c = start_ok_c;
            S_START: begin
                if (tick_c) begin
                    state_d = S_DATA;
                    cnt_d   = div_q;
                    bit_d   = 3'd0;
                    txd_d   = shift_q[0];
                end else cnt_d = cnt_q - DIV_W'(1);
            end
            S_DATA: begin
                if (tick_c) begin
                    cnt_d = div_q;
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                        txd_d   = 1'b1;
`ifdef UART_TX_PARITY_EN
                        if (ctrl_q[CTRL_PAR_EN]) begin
                            state_d = S_PARITY;
                            txd_d   = par_q;
                        end
`endif
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = {1'b0, shift_q[7:1]};
                        txd_d   = shift_q[1];
                    end
                end else cnt_d = cnt_q - DIV_W'(1);
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (tick_c) begin
                    state_d = S_STOP;
                    cnt_d   = div_q;
                    txd_d   = 1'b1;
                end else cnt_d = cnt_q - DIV_W'(1);
            end
`endif
            S_STOP: begin
                if (tick_c) begin
                    if (start_ok_c) load_c  = 1'b1;
                    else            state_d = S_IDLE;
                end else cnt_d = cnt_q - DIV_W'(1);
            end
            default: state_d = S_IDLE;
        endcase
        // Pop the next byte and begin its start bit; shared by IDLE and STOP.
        if (load_c) begin
            pop_c   = 1'b1;
            shift_d = fifo_rdata_c;
            state_d = S_START;
            cnt_d   = div_q;
            txd_d   = 1'b0;
`ifdef UART_TX_PARITY_EN
            par_d   = (^fifo_rdata_c) ^ ctrl_q[CTRL_PAR_ODD];
`endif
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            ack_q   <= 1'b0;
            dat_q   <= '0;
            div_q   <= DIV_W'(DEFAULT_DIV);
            ctrl_q  <= '0;
            ovf_q   <= 1'b0;
            int_q   <= 1'b0;
            txd_q   <= 1'b1;
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            ack_q   <= ack_d;
            dat_q   <= dat_d;
            div_q   <= div_d;
            ctrl_q  <= ctrl_d;
            ovf_q   <= ovf_d;
            int_q   <= int_d;
            txd_q   <= txd_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
`ifdef UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign wb.wb_ack_o = ack_q;
    assign wb.wb_dat_o = dat_q;
    assign uart_txd_o  = txd_q;
    assign uart_int_o  = int_q;

endmodule
